// File: rtl/mem_stage.sv
// mem_stage: pipeline MEM stage between the EX/MEM boundary and the
// control/writeback unit. Issues load/store accesses on the shared bus
// with a ready handshake, traps misaligned accesses, buffers read data
// across external stalls and drives the registered MEM pipeline register.
//
// Ports:
//   clk, reset        clock, synchronous active-high reset
//   ex_*              EX stage outputs (valid, pc, memory op, address/result,
//                     store data, destination, write enable, ctrl op, exception)
//   stall, flush      MEM stall / flush from the control unit
//   bus_*             shared bus request/handshake and data
//   mem_busy          access outstanding, consumed by the control unit
//   mem_*             registered MEM pipeline register
module mem_stage #(
   parameter int ADDR_W       = 32,
   parameter int DATA_W       = 32,
   parameter int REG_W        = 5,
   parameter int EXP_W        = 3,
   parameter int EXP_NOEXP    = 0,
   parameter int EXP_MISALIGN = 5
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              ex_en,
   input  logic [ADDR_W-1:0] ex_pc,
   input  logic              ex_br_flag,
   input  logic [1:0]        ex_mem_op,
   input  logic [DATA_W-1:0] ex_out,
   input  logic [DATA_W-1:0] ex_mem_wr_data,
   input  logic [REG_W-1:0]  ex_dst_addr,
   input  logic              ex_gpr_we_,
   input  logic [1:0]        ex_ctrl_op,
   input  logic [EXP_W-1:0]  ex_exp_code,
   input  logic              stall,
   input  logic              flush,
   input  logic [DATA_W-1:0] bus_rd_data,
   input  logic              bus_rdy,
   output logic              bus_req,
   output logic              bus_rw,
   output logic [ADDR_W-1:0] bus_addr,
   output logic [DATA_W-1:0] bus_wr_data,
   output logic              mem_busy,
   output logic              mem_en,
   output logic [ADDR_W-1:0] mem_pc,
   output logic              mem_br_flag,
   output logic [1:0]        mem_ctrl_op,
   output logic [REG_W-1:0]  mem_dst_addr,
   output logic              mem_gpr_we_,
   output logic [EXP_W-1:0]  mem_exp_code,
   output logic [DATA_W-1:0] mem_out
);

   localparam logic [EXP_W-1:0] NOEXP    = EXP_W'(EXP_NOEXP);
   localparam logic [EXP_W-1:0] MISALIGN = EXP_W'(EXP_MISALIGN);

   typedef enum logic [1:0] {IDLE, WAIT, HOLD, DRAIN} state_t;

   state_t            state, state_nx;
   logic              is_ld, is_st, is_mem, no_exp, aligned, misalign, acc;
   logic              req_raw, busy_raw, hold_load;
   logic [ADDR_W-1:0] ex_addr, addr_q;
   logic              rw_q;
   logic [DATA_W-1:0] wr_data_q, hold_buf;

   assign is_ld    = (ex_mem_op == 2'b01);
   assign is_st    = (ex_mem_op == 2'b10);
   assign is_mem   = is_ld | is_st;
   assign no_exp   = (ex_exp_code == NOEXP);
   assign aligned  = (ex_out[1:0] == 2'b00);
   assign misalign = ex_en & is_mem & no_exp & ~aligned;
   assign acc      = ex_en & is_mem & no_exp & aligned & ~flush;
   assign ex_addr  = ex_out[ADDR_W-1:0] & ~ADDR_W'(3);

   always_ff @(posedge clk) begin
      if (reset) state <= IDLE;
      else       state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      req_raw  = 1'b0;
      unique case (state)
         IDLE: begin
            req_raw = acc;
            if (acc) begin
               if (bus_rdy) state_nx = stall ? HOLD : IDLE;
               else         state_nx = WAIT;
            end
         end
         WAIT: begin
            req_raw = 1'b1;
            // A flush coinciding with rdy simply drops the data.
            if (bus_rdy)    state_nx = (stall & ~flush) ? HOLD : IDLE;
            else if (flush) state_nx = DRAIN;
         end
         HOLD: begin
            if (flush | ~stall) state_nx = IDLE;
         end
         DRAIN: begin
            req_raw = 1'b1;
            if (bus_rdy) state_nx = IDLE;
         end
         default: state_nx = IDLE;
      endcase
   end

   assign busy_raw  = (req_raw & ~bus_rdy) | ((state == DRAIN) & ~bus_rdy);
   assign bus_req   = req_raw & ~reset;
   assign mem_busy  = busy_raw & ~reset;
   assign hold_load = bus_rdy & stall & ~flush &
                      (((state == IDLE) & acc) | (state == WAIT));

   // Bus fields are sampled while IDLE so they stay frozen for the whole
   // transaction, even when EX moves on during a DRAIN.
   always_ff @(posedge clk) begin
      if (state == IDLE) begin
         addr_q    <= ex_addr;
         rw_q      <= is_st;
         wr_data_q <= ex_mem_wr_data;
      end
   end

   assign bus_addr    = (state == IDLE) ? ex_addr        : addr_q;
   assign bus_rw      = (state == IDLE) ? is_st          : rw_q;
   assign bus_wr_data = (state == IDLE) ? ex_mem_wr_data : wr_data_q;

   always_ff @(posedge clk) begin
      if (reset)          hold_buf <= '0;
      else if (hold_load) hold_buf <= bus_rd_data;
   end

   // Pipeline register. An outstanding access also holds the register so a
   // load never captures data before its rdy cycle.
   always_ff @(posedge clk) begin
      if (reset) begin
         mem_en       <= 1'b0;
         mem_pc       <= '0;
         mem_br_flag  <= 1'b0;
         mem_ctrl_op  <= '0;
         mem_dst_addr <= '0;
         mem_gpr_we_  <= 1'b1;
         mem_exp_code <= NOEXP;
         mem_out      <= '0;
      end else if (flush) begin
         mem_en       <= 1'b0;
         mem_gpr_we_  <= 1'b1;
         mem_exp_code <= NOEXP;
      end else if (!(stall | busy_raw)) begin
         mem_en       <= ex_en;
         mem_pc       <= ex_pc;
         mem_br_flag  <= ex_br_flag;
         mem_ctrl_op  <= ex_ctrl_op;
         mem_dst_addr <= ex_dst_addr;
         mem_gpr_we_  <= misalign ? 1'b1 : ex_gpr_we_;
         mem_exp_code <= !no_exp ? ex_exp_code : (misalign ? MISALIGN : NOEXP);
         mem_out      <= is_ld ? ((state == HOLD) ? hold_buf : bus_rd_data) : ex_out;
      end
   end

endmodule
